// File: rtl/carry_chain_adder_pipe.sv
// Pipelined adder/subtractor built as a segmented carry chain with whole-pipeline stall.
// Optional signed saturation of the result when CARRY_CHAIN_SAT_EN is defined.
module carry_chain_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic advance;

  // Per-stage view: operands (skewed), partial result (deskewed), carry into segment, valid
  logic [WIDTH-1:0] op_a     [STAGES];
  logic [WIDTH-1:0] op_b     [STAGES];
  logic [WIDTH-1:0] part     [STAGES];
  logic             carry    [STAGES];
  logic             vld      [STAGES];
  logic [SEG:0]     seg_res  [STAGES];
  logic [WIDTH-1:0] nxt_part [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign op_a[0]  = a;
  assign op_b[0]  = sub ? ~b : b;
  assign part[0]  = '0;
  assign carry[0] = cin;
  assign vld[0]   = in_valid;

  // Stage k adds segment k and merges it into the partial result
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    assign seg_res[k]  = {1'b0, op_a[k][k*SEG +: SEG]} + {1'b0, op_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, carry[k]};
    assign nxt_part[k] = (part[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                       | (WIDTH'(seg_res[k][SEG-1:0]) << (k*SEG));
  end

  if (STAGES > 1) begin : g_pipe
    logic [WIDTH-1:0] a_p     [1:STAGES-1];
    logic [WIDTH-1:0] b_p     [1:STAGES-1];
    logic [WIDTH-1:0] part_p  [1:STAGES-1];
    logic             carry_p [1:STAGES-1];
    logic             vld_p   [1:STAGES-1];

    // Stage boundaries 0 .. STAGES-2: valids are the only reset state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 1; k < STAGES; k++) vld_p[k] <= 1'b0;
      end else if (advance) begin
        for (int k = 1; k < STAGES; k++) vld_p[k] <= vld[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        for (int k = 1; k < STAGES; k++) begin
          a_p[k]     <= op_a[k-1];
          b_p[k]     <= op_b[k-1];
          part_p[k]  <= nxt_part[k-1];
          carry_p[k] <= seg_res[k-1][SEG];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_tap
      assign op_a[k]  = a_p[k];
      assign op_b[k]  = b_p[k];
      assign part[k]  = part_p[k];
      assign carry[k] = carry_p[k];
      assign vld[k]   = vld_p[k];
    end
  end

  logic signed [WIDTH-1:0] raw_sum;
  logic signed [WIDTH-1:0] sum_n;
  logic                    cout_n;
  logic                    msb_carry;
  logic                    ovf_n;

  assign raw_sum   = nxt_part[LAST];
  assign cout_n    = seg_res[LAST][SEG];
  // Carry into the MSB recovered from the MSB sum bit and its two operand bits
  assign msb_carry = op_a[LAST][WIDTH-1] ^ op_b[LAST][WIDTH-1] ^ raw_sum[WIDTH-1];
  assign ovf_n     = msb_carry ^ cout_n;

`ifdef CARRY_CHAIN_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_signed(input logic signed [WIDTH-1:0] s,
                                                         input logic ov);
    if (!ov) return s;
    return s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
  assign sum_n = sat_signed(raw_sum, ovf_n);
`else
  assign sum_n = raw_sum;
`endif

  // Stage STAGES-1: output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= vld[LAST];
      sum       <= sum_n;
      cout      <= cout_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_carry_chain_adder_pipe.sv
// Self-checking bench for carry_chain_adder_pipe: 16-bit/4-stage and 8-bit/1-stage instances.
module tb_carry_chain_adder_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic       s1_in_valid, s1_in_ready, s1_sub, s1_cin, s1_out_valid, s1_out_ready, s1_cout, s1_ovf;
  logic [7:0] s1_a, s1_b, s1_sum;

  carry_chain_adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  carry_chain_adder_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .sub(s1_sub), .cin(s1_cin), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] s, input logic ov);
`ifdef CARRY_CHAIN_SAT_EN
    if (ov) return s[15] ? 16'h7FFF : 16'h8000;
`endif
    return s;
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] s, input logic ov);
`ifdef CARRY_CHAIN_SAT_EN
    if (ov) return s[7] ? 8'h7F : 8'h80;
`endif
    return s;
  endfunction

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    logic [15:0] yy;
    logic [16:0] full;
    logic        ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, c};
    ov   = (x[15] == yy[15]) && (full[15] != x[15]);
    return {ov, full[16], sat16(full[15:0], ov)};
  endfunction

  task automatic drive(input vec_t v);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
  endtask

  logic [17:0] q[$];
  logic [17:0] exp_r, held;
  logic        hold_prev;
  int          sent, got;
  logic        pat[4];

  initial begin
    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_a = '0; s1_b = '0; s1_sub = 1'b0; s1_cin = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // Latency: accepted at E0, visible after E3
    drive(vecs[0]);
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      chk("lat_not_yet", out_valid, (e == 3) ? 0 : 0);
      if (e < 3) tick();
    end
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_sum", sum, sat16(vecs[0].sum, vecs[0].ovf));
    chk("lat_cout", cout, vecs[0].cout);
    chk("lat_ovf", ovf, vecs[0].ovf);

    // Back-to-back table stream, one beat per clock
    for (int c = 0; c < 12 + 3; c++) begin
      if (c < 12) drive(vecs[c]);
      else in_valid = 1'b0;
      tick();
      if (c >= 3) begin
        chk($sformatf("stream_valid[%0d]", c - 3), out_valid, 1);
        chk($sformatf("stream_sum[%0d]", c - 3), sum, sat16(vecs[c-3].sum, vecs[c-3].ovf));
        chk($sformatf("stream_cout[%0d]", c - 3), cout, vecs[c-3].cout);
        chk($sformatf("stream_ovf[%0d]", c - 3), ovf, vecs[c-3].ovf);
      end
    end
    tick();
    chk("stream_drained", out_valid, 0);

    // Back-pressure with random beats and out_ready pattern 1,0,0,1
    sent = 0; got = 0; hold_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      out_ready = pat[cyc % 4];
      if (sent < 16 && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_prev) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", {ovf, cout, sum}, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("bp_unexpected_beat", 1, 0);
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("bp_beat[%0d]", got), {ovf, cout, sum}, exp_r);
        end
        got++;
      end
      hold_prev = out_valid && !out_ready;
      held      = {ovf, cout, sum};
      if (in_valid && in_ready) begin
        q.push_back(ref16(a, b, sub, cin));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 16);
    chk("bp_received", got, 16);
    chk("bp_queue_empty", q.size(), 0);

    // Mid-stream reset with a full, stalled pipeline
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sum", sum, 16'h3333);
    chk("pre_rst_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_ovf", ovf, 0);
    #2 reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_flushed", out_valid, 0);
      tick();
    end

    // Single-stage 8-bit instance: latency 1
    s1_a = 8'h7F; s1_b = 8'h01; s1_sub = 1'b0; s1_cin = 1'b0; s1_in_valid = 1'b1;
    #1;
    chk("s1_idle_valid", s1_out_valid, 0);
    chk("s1_in_ready", s1_in_ready, 1);
    tick();
    s1_in_valid = 1'b0;
    chk("s1_valid", s1_out_valid, 1);
    chk("s1_sum", s1_sum, sat8(8'h80, 1'b1));
    chk("s1_ovf", s1_ovf, 1);
    chk("s1_cout", s1_cout, 0);
    tick();
    chk("s1_bubble", s1_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
